// File: rtl/vote_count_bank_if.sv
// Vote/scan bundle between the vote source, the vote_count_bank and the max-search consumer.
// The master side produces votes and frame control; the slave side is the counter bank.
interface vote_count_bank_if #(
  parameter int NUM = 18,
  parameter int CW  = 7,
  parameter int IW  = 5
);
  logic              i_valid;
  logic [IW-1:0]     i_idx;
  logic              i_frame_end;
  logic              i_clr;
  logic              o_ready;
  logic              o_drop;
  logic [NUM*CW-1:0] o_cnt;
  logic              o_cnt_clr;
  logic              o_cnt_en;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_valid, i_idx, i_frame_end, i_clr,
    input  o_ready, o_drop, o_cnt, o_cnt_clr, o_cnt_en, o_busy, o_done
  );

  modport slave (
    input  i_valid, i_idx, i_frame_end, i_clr,
    output o_ready, o_drop, o_cnt, o_cnt_clr, o_cnt_en, o_busy, o_done
  );
endinterface

// File: rtl/vote_count_bank.sv
// Per-class saturating vote counters with a frame-end scan handshake (clr, NUM x en, done)
// feeding the downstream max-search block.
module vote_count_bank #(
  parameter int NUM = 18,
  parameter int CW  = 7,
  parameter int IW  = 5
) (
  input logic              clk,
  input logic              rst,
  vote_count_bank_if.slave bus
);

  localparam int SW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(NUM - 1);
  localparam logic [IW:0]   IDX_LIM   = (IW + 1)'(NUM);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_CLR   = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [SW-1:0]     scan_r;
  logic [SW-1:0]     scan_s;
  logic [NUM*CW-1:0] cnt_r;
  logic [NUM*CW-1:0] cnt_s;
  logic              vote_ok_s;
  logic              ready_r;
  logic              busy_r;
  logic              drop_r;
  logic              cnt_clr_r;
  logic              cnt_en_r;
  logic              done_r;

  // State and scan-index register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ACCUM;
      scan_r  <= {SW{1'b0}};
    end else begin
      state_r <= state_s;
      scan_r  <= scan_s;
    end
  end

  // Next-state and scan-index sequencing
  always_comb begin
    state_s = state_r;
    scan_s  = scan_r;
    case (state_r)
      ST_ACCUM: begin
        scan_s = {SW{1'b0}};
        if (bus.i_frame_end) begin
          state_s = ST_CLR;
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_CLR: begin
        scan_s  = {SW{1'b0}};
        state_s = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_r == SCAN_LAST) begin
          scan_s  = {SW{1'b0}};
          state_s = ST_DONE;
        end else begin
          scan_s  = scan_r + SW'(1);
          state_s = ST_SCAN;
        end
      end
      ST_DONE: begin
        scan_s  = {SW{1'b0}};
        state_s = ST_ACCUM;
      end
      default: begin
        scan_s  = {SW{1'b0}};
        state_s = ST_ACCUM;
      end
    endcase
  end

  assign vote_ok_s = bus.i_valid && ({1'b0, bus.i_idx} < IDX_LIM);

  // Counter update: clear wins over a vote, frame end wins over clear, frozen outside ACCUM
  always_comb begin
    cnt_s = cnt_r;
    case (state_r)
      ST_ACCUM: begin
        if (bus.i_clr && !bus.i_frame_end) begin
          cnt_s = {(NUM*CW){1'b0}};
        end else if (vote_ok_s) begin
          for (int k = 0; k < NUM; k++) begin
            if ((bus.i_idx == IW'(k)) && (cnt_r[k*CW +: CW] != CNT_MAX)) begin
              cnt_s[k*CW +: CW] = cnt_r[k*CW +: CW] + CW'(1);
            end else begin
              cnt_s[k*CW +: CW] = cnt_r[k*CW +: CW];
            end
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_CLR:  cnt_s = cnt_r;
      ST_SCAN: cnt_s = cnt_r;
      ST_DONE: cnt_s = {(NUM*CW){1'b0}};
      default: cnt_s = {(NUM*CW){1'b0}};
    endcase
  end

  // Counter bank and registered handshake outputs, decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= {(NUM*CW){1'b0}};
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      drop_r    <= 1'b0;
      cnt_clr_r <= 1'b0;
      cnt_en_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      ready_r   <= (state_s == ST_ACCUM);
      busy_r    <= (state_s != ST_ACCUM);
      drop_r    <= bus.i_valid && (state_r != ST_ACCUM);
      cnt_clr_r <= (state_s == ST_CLR);
      cnt_en_r  <= (state_s == ST_SCAN);
      done_r    <= (state_s == ST_DONE);
    end
  end

  assign bus.o_cnt     = cnt_r;
  assign bus.o_ready   = ready_r;
  assign bus.o_busy    = busy_r;
  assign bus.o_drop    = drop_r;
  assign bus.o_cnt_clr = cnt_clr_r;
  assign bus.o_cnt_en  = cnt_en_r;
  assign bus.o_done    = done_r;

endmodule

// File: tb/tb_vote_count_bank.sv
// Scoreboarded bench for vote_count_bank: a reference vote model snapshots each frame,
// and a max-search consumer model checks the scan handshake, timing and result.
module tb_vote_count_bank;
  localparam int NUM = 18;
  localparam int CW  = 7;
  localparam int IW  = 5;

  typedef struct {
    logic [NUM*CW-1:0] cnt;
    int                max_v;
    int                max_i;
    int                clr_cyc;
    int                done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   done_seen    = 0;
  int   model[NUM];
  exp_t sb_q[$];
  int   en_n, cons_max, cons_idx, cons_val;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vote_count_bank_if #(.NUM(NUM), .CW(CW), .IW(IW)) bus ();

  vote_count_bank #(.NUM(NUM), .CW(CW), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM*CW-1:0] pack_model();
    logic [NUM*CW-1:0] v;
    for (int k = 0; k < NUM; k++) v[k*CW +: CW] = model[k][CW-1:0];
    return v;
  endfunction

  function automatic void clear_model();
    for (int k = 0; k < NUM; k++) model[k] = 0;
  endfunction

  function automatic void apply_vote(input int idx);
    if (idx < NUM && model[idx] < 127) model[idx] = model[idx] + 1;
  endfunction

  // Consumer model: max-search over the scanned fields, checked against the scoreboard at done
  always @(negedge clk) begin
    if (bus.o_cnt_clr) begin
      en_n = 0; cons_max = 0; cons_idx = 0;
      check("clr_en_excl", bus.o_cnt_en, 0);
      if (sb_q.size() > 0) begin
        check("clr_cnt", bus.o_cnt, sb_q[0].cnt);
        check("clr_cyc", cyc, sb_q[0].clr_cyc);
      end else begin
        check("unexp_clr", 1, 0);
      end
    end
    if (bus.o_cnt_en) begin
      if (en_n < NUM) begin
        cons_val = int'(bus.o_cnt[en_n*CW +: CW]);
        if (cons_val > cons_max) begin
          cons_max = cons_val;
          cons_idx = en_n;
        end
      end
      en_n++;
    end
    if (bus.o_done) begin
      done_seen++;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_cyc", cyc, e.done_cyc);
        check("en_cycles", en_n, NUM);
        check("max_val", cons_max, e.max_v);
        check("max_idx", cons_idx, e.max_i);
        check("done_cnt", bus.o_cnt, e.cnt);
      end else begin
        check("unexp_done", 1, 0);
      end
    end
  end

  task automatic vote(input int idx);
    bus.i_valid = 1'b1;
    bus.i_idx   = 5'(idx);
    tick();
    bus.i_valid = 1'b0;
    apply_vote(idx);
  endtask

  task automatic frame_start(input bit with_vote, input int vidx, input bit with_clr);
    exp_t e;
    bus.i_frame_end = 1'b1;
    bus.i_clr       = with_clr;
    if (with_vote) begin
      bus.i_valid = 1'b1;
      bus.i_idx   = 5'(vidx);
      apply_vote(vidx);
    end
    e.cnt = pack_model();
    e.max_v = 0; e.max_i = 0;
    for (int k = 0; k < NUM; k++) begin
      if (model[k] > e.max_v) begin
        e.max_v = model[k];
        e.max_i = k;
      end
    end
    e.clr_cyc  = cyc + 1;
    e.done_cyc = cyc + NUM + 2;
    sb_q.push_back(e);
    tick();
    bus.i_frame_end = 1'b0;
    bus.i_clr       = 1'b0;
    bus.i_valid     = 1'b0;
  endtask

  task automatic frame_wait();
    for (int i = 0; i < NUM + 10 && sb_q.size() > 0; i++) tick();
    check("frame_timeout", sb_q.size(), 0);
    tick();
    clear_model();
    check("post_cnt_zero", bus.o_cnt, 0);
    check("post_ready", bus.o_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    clear_model();
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_idx = '0; bus.i_frame_end = 1'b0; bus.i_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rst_cnt", bus.o_cnt, 0);
    check("rst_ready", bus.o_ready, 1);
    check("rst_en", bus.o_cnt_en, 0);
    check("rst_clr", bus.o_cnt_clr, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_busy", bus.o_busy, 0);

    // Basic frame: argmax 11 with 5 votes
    repeat (3) vote(4);
    repeat (5) vote(11);
    vote(17);
    check("accum_cnt", bus.o_cnt, pack_model());
    check("field11", bus.o_cnt[11*CW +: CW], 5);
    frame_start(1'b0, 0, 1'b0);
    check("busy_clr", bus.o_busy, 1);
    frame_wait();

    // Saturation and out-of-range indices
    repeat (130) vote(2);
    check("sat_field2", bus.o_cnt[2*CW +: CW], 127);
    vote(18);
    check("drop_idx18", bus.o_drop, 0);
    vote(31);
    check("drop_idx31", bus.o_drop, 0);
    check("sat_cnt", bus.o_cnt, pack_model());

    // Vote coincident with frame end is scanned; votes during scan are dropped
    vote(9);
    frame_start(1'b1, 9, 1'b0);
    repeat (3) tick();
    bus.i_valid = 1'b1; bus.i_idx = 5'd3;
    tick();
    bus.i_valid = 1'b0;
    check("scan_drop", bus.o_drop, 1);
    check("scan_ready", bus.o_ready, 0);
    check("scan_busy", bus.o_busy, 1);
    check("scan_frozen", bus.o_cnt, pack_model());
    tick();
    check("scan_drop_end", bus.o_drop, 0);
    frame_wait();

    // Clear behaviour
    for (int i = 0; i < 10; i++) vote(i);
    check("pre_clr", bus.o_cnt, pack_model());
    bus.i_clr = 1'b1; bus.i_valid = 1'b1; bus.i_idx = 5'd5;
    tick();
    bus.i_clr = 1'b0; bus.i_valid = 1'b0;
    clear_model();
    check("clr_zero", bus.o_cnt, 0);
    repeat (2) vote(7);
    vote(0);
    frame_start(1'b0, 0, 1'b1);
    check("clr_fe_kept", bus.o_cnt, pack_model());
    frame_wait();

    // Reset during the 7th scan-enable cycle
    repeat (4) vote(6);
    frame_start(1'b0, 0, 1'b0);
    repeat (7) tick();
    check("pre_rst_en", bus.o_cnt_en, 1);
    d0 = done_seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    clear_model();
    check("mrst_en", bus.o_cnt_en, 0);
    check("mrst_busy", bus.o_busy, 0);
    check("mrst_ready", bus.o_ready, 1);
    check("mrst_cnt", bus.o_cnt, 0);
    check("mrst_done", bus.o_done, 0);
    repeat (25) tick();
    check("mrst_no_done", done_seen, d0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/vote_count_bank.md
Name: vote_count_bank

Overview:
- Per-class vote accumulator that produces the packed counter vector consumed by the downstream max-search block.
- Accumulates class-index events into NUM saturating counters. On frame end, it freezes the counters and drives the scan handshake: one o_cnt_clr cycle, then exactly NUM o_cnt_en cycles.
- After the scan it pulses o_done, zeroes the bank and returns to accumulation.

Parameters:
- NUM, 18, number of classes/counters.
- CW, 7, counter width. Must stay 7 for compatibility with the max-search consumer.
- IW, 5, class-index width. Requires 2^IW >= NUM.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  vote event strobe.
- i_idx  in  IW  class index of the vote.
- i_frame_end  in  1  end-of-frame request; starts the scan.
- i_clr  in  1  zero all counters (honoured in ACCUM only).
- o_ready  out  1  high in ACCUM; votes are accepted only when high.
- o_drop  out  1  one-cycle pulse when i_valid=1 arrives while o_ready=0.
- o_cnt  out  NUM*CW  packed counters; class k at bits [k*CW +: CW].
- o_cnt_clr  out  1  clear strobe to the consumer.
- o_cnt_en  out  1  scan-enable to the consumer.
- o_busy  out  1  high in CLR, SCAN and DONE.
- o_done  out  1  one-cycle pulse; the consumer result is valid this cycle.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All counters 0, state ACCUM, scan counter 0.
  - o_cnt_clr=0, o_cnt_en=0, o_done=0, o_drop=0, o_busy=0, o_ready=1.
  - rst overrides every other input in every state. A reset mid-scan deasserts o_cnt_en the following cycle and zeroes the counters.
- All outputs are registered.
- States: ACCUM, CLR, SCAN, DONE.
- ACCUM:
  - i_valid=1 with i_idx<NUM: counter[i_idx] += 1, saturating at 2^CW-1 (127). No wrap.
  - i_valid=1 with i_idx>=NUM: ignored, no drop pulse.
  - i_clr=1: all counters are zeroed. i_clr has priority over a same-cycle vote.
  - i_frame_end=1: next state CLR. A vote in the same cycle is still counted.
  - i_frame_end has priority over i_clr: the scan starts, i_clr is ignored, counters are kept.
- CLR:
  - One cycle with o_cnt_clr=1 and o_cnt_en=0.
  - Scan counter is 0. Next state SCAN.
- SCAN:
  - o_cnt_en=1 for exactly NUM consecutive cycles.
  - Scan counter runs 0..NUM-1. At NUM-1 the next state is DONE.
  - Counters are frozen for the whole scan.
- DONE:
  - One cycle with o_done=1 and o_cnt_en=0.
  - All counters are zeroed at the end of this cycle. Next state ACCUM.
- Outside ACCUM:
  - o_ready=0 and votes are not applied. i_valid=1 produces o_drop=1 on the next cycle.
  - i_frame_end and i_clr are ignored.
- Latency: i_frame_end sampled at edge T gives:
  - o_cnt_clr high in cycle T+1.
  - o_cnt_en high in cycles T+2..T+NUM+1.
  - o_done high in cycle T+NUM+2.
  - o_ready high again from T+NUM+3.
- o_cnt_en never asserts together with o_cnt_clr and never exceeds NUM cycles, so the consumer's internal scan counter starts at 0 and ends at NUM-1.
- o_cnt holds the counter values unchanged from the CLR cycle through the DONE cycle.

Test Plan:
- Reset then idle for 5 cycles -> o_cnt all 0, o_ready=1, o_cnt_en=o_cnt_clr=o_done=0.
- 3 votes idx 4, 5 votes idx 11, 1 vote idx 17, then i_frame_end -> o_cnt fields 4:3, 11:5, 17:1, others 0. Then o_cnt_clr for 1 cycle, o_cnt_en for exactly 18 cycles, o_done 20 cycles after frame end. With the consumer attached: max=5, idx=11. After DONE all counters are 0.
- 130 votes to idx 2 -> field 2 saturates at 127, no wrap. 1 vote idx 18 and 1 vote idx 31 -> ignored, no o_drop.
- i_valid pulsed during SCAN -> o_drop pulses, counters unchanged, o_ready=0. A vote in the same cycle as i_frame_end in ACCUM -> that vote is included in the scanned values.
- i_clr after 10 votes -> all 0. i_clr together with i_frame_end -> scan proceeds with counters intact.
- rst asserted at the 7th o_cnt_en cycle -> next cycle o_cnt_en=0, o_busy=0, o_ready=1, all counters 0, no o_done pulse.
